// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction sequencer: field widths, opcode
// constants, datapath-op classification and the fetch FSM state type.
package isa_pkg;

  localparam int OPC_W   = 5;
  localparam int OPR_W   = 12;
  localparam int INSTR_W = OPC_W + OPR_W;

  localparam logic [OPC_W-1:0] OP_LDAC  = 5'd3;
  localparam logic [OPC_W-1:0] OP_LDIAC = 5'd5;
  localparam logic [OPC_W-1:0] OP_STAC  = 5'd8;
  localparam logic [OPC_W-1:0] OP_MVAC  = 5'd9;
  localparam logic [OPC_W-1:0] OP_MOVR  = 5'd10;
  localparam logic [OPC_W-1:0] OP_ADD   = 5'd19;
  localparam logic [OPC_W-1:0] OP_SUB   = 5'd20;
  localparam logic [OPC_W-1:0] OP_INAC  = 5'd23;
  localparam logic [OPC_W-1:0] OP_JPNZ  = 5'd24;
  localparam logic [OPC_W-1:0] OP_JMPZ  = 5'd26;
  localparam logic [OPC_W-1:0] OP_NOP   = 5'd28;
  localparam logic [OPC_W-1:0] OP_CLAC  = 5'd30;
  localparam logic [OPC_W-1:0] OP_ENDOP = 5'd31;

  // Codes 3, 5, 8..23 and 30 are executed by the datapath; everything else
  // is either resolved locally by the sequencer or undefined.
  function automatic logic is_datapath_op(input logic [OPC_W-1:0] opc);
    return (opc == OP_LDAC) || (opc == OP_LDIAC) || (opc == OP_CLAC) ||
           ((opc >= OP_STAC) && (opc <= OP_INAC));
  endfunction

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    ISSUE  = 3'd3,
    HALT   = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Issue/retire handshake between the sequencer and the datapath, plus the
// datapath zero flag consumed by conditional branches.
interface fetch_unit_if #(
  parameter int OPC_W = 5,
  parameter int OPR_W = 12
) ();

  logic             op_valid;
  logic [OPC_W-1:0] opcode;
  logic [OPR_W-1:0] operand;
  logic             op_ready;
  logic             z_flag;

  modport master (
    output op_valid,
    output opcode,
    output operand,
    input  op_ready,
    input  z_flag
  );

  modport slave (
    input  op_valid,
    input  opcode,
    input  operand,
    output op_ready,
    output z_flag
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction sequencer: owns the PC, fetches from a 1-cycle-latency ROM,
// resolves branches/nop/endop locally and issues datapath ops over dp.
module fetch_unit
  import isa_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic [INSTR_W-1:0] instr_in,
  fetch_unit_if.master       dp,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [OPC_W-1:0]   opcode_q, opcode_d;
  logic [OPR_W-1:0]   operand_q, operand_d;
  logic               op_valid_q, op_valid_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [OPC_W-1:0]   dec_opc;
  logic [OPR_W-1:0]   dec_opr;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  br_target;
  logic [CNT_W-1:0]   cnt_inc;

  assign dec_opc   = instr_in[INSTR_W-1 -: OPC_W];
  assign dec_opr   = instr_in[OPR_W-1:0];
  assign pc_inc    = pc_q + ADDR_W'(1);
  assign br_target = dec_opr[ADDR_W-1:0];
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d   = FETCH;
          pc_d      = '0;
          cnt_d     = '0;
          illegal_d = 1'b0;
        end
      end

      FETCH: state_d = DECODE;

      DECODE: begin
        // The IR is loaded every decode so opcode/operand are already stable
        // on the cycle op_valid rises.
        opcode_d  = dec_opc;
        operand_d = dec_opr;
        if (dec_opc == OP_JPNZ) begin
          pc_d    = dp.z_flag ? pc_inc : br_target;
          cnt_d   = cnt_inc;
          state_d = FETCH;
        end else if (dec_opc == OP_JMPZ) begin
          pc_d    = dp.z_flag ? br_target : pc_inc;
          cnt_d   = cnt_inc;
          state_d = FETCH;
        end else if (dec_opc == OP_ENDOP) begin
          cnt_d   = cnt_inc;
          state_d = HALT;
        end else if (is_datapath_op(dec_opc)) begin
          state_d = ISSUE;
        end else begin
          // nop and undefined codes both just advance; undefined ones flag.
          if (dec_opc != OP_NOP) illegal_d = 1'b1;
          pc_d    = pc_inc;
          cnt_d   = cnt_inc;
          state_d = FETCH;
        end
      end

      ISSUE: begin
        if (op_valid_q && dp.op_ready) begin
          pc_d    = pc_inc;
          cnt_d   = cnt_inc;
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase

    op_valid_d = (state_d == ISSUE);
    busy_d     = (state_d == FETCH) || (state_d == DECODE) || (state_d == ISSUE);
    halted_d   = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      opcode_q   <= '0;
      operand_q  <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_out      = pc_q;
  assign dp.op_valid = op_valid_q;
  assign dp.opcode   = opcode_q;
  assign dp.operand  = operand_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural registered ROM, datapath stub
// driven from the stimulus block, immediate-assertion checks per step.
module tb_fetch_unit;
  import isa_pkg::*;

  localparam int ADDR_W = 11;
  localparam int CNT_W  = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [ADDR_W-1:0]  pc_out;
  logic [INSTR_W-1:0] instr_in;
  logic               busy, halted, illegal;
  logic [CNT_W-1:0]   instr_count;

  logic [INSTR_W-1:0] rom [2048];

  int vectors     = 0;
  int miscompares = 0;

  logic [OPC_W-1:0] issued [8];
  int               n_iss = 0;

  fetch_unit_if #(.OPC_W(OPC_W), .OPR_W(OPR_W)) dpif ();

  fetch_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pc_out      (pc_out),
    .instr_in    (instr_in),
    .dp          (dpif.master),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr_in <= rom[pc_out];

  always @(posedge clk) begin
    if (!rst && dpif.op_valid && dpif.op_ready && n_iss < 8) begin
      issued[n_iss] = dpif.opcode;
      n_iss = n_iss + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = {OP_NOP, 12'h000};
  endtask

  task automatic run_to_halt(input int bound, output int cycles, output logic saw_valid);
    cycles    = 0;
    saw_valid = 1'b0;
    while (!halted && cycles < bound) begin
      tick();
      cycles++;
      if (dpif.op_valid) saw_valid = 1'b1;
    end
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (!dpif.op_valid && n < bound) begin
      tick();
      n++;
    end
  endtask

  logic [OPC_W-1:0] br_op  [4];
  logic             br_z   [4];
  logic [ADDR_W-1:0] br_pc [4];

  initial begin
    int   cyc;
    logic saw;

    rst = 1'b1;
    start = 1'b0;
    dpif.op_ready = 1'b0;
    dpif.z_flag = 1'b0;
    clear_rom();

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_pc", 32'(pc_out), 0);
    check("rst_valid", 32'(dpif.op_valid), 0);
    check("rst_opcode", 32'(dpif.opcode), 0);
    check("rst_operand", 32'(dpif.operand), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_count", 32'(instr_count), 0);
    tick();
    check("idle_busy", 32'(busy), 0);

    // clac, inac, endop with op_ready tied high
    rom[0] = {OP_CLAC, 12'h000};
    rom[1] = {OP_INAC, 12'h000};
    rom[2] = {OP_ENDOP, 12'h000};
    dpif.op_ready = 1'b1;
    n_iss = 0;
    start_pulse();
    check("prog_busy", 32'(busy), 1);
    check("prog_pc0", 32'(pc_out), 0);
    run_to_halt(30, cyc, saw);
    check("prog_halted", 32'(halted), 1);
    check("prog_cycles", 32'(cyc), 8);
    check("prog_n_issues", 32'(n_iss), 2);
    check("prog_iss0", 32'(issued[0]), 32'(OP_CLAC));
    check("prog_iss1", 32'(issued[1]), 32'(OP_INAC));
    check("prog_count", 32'(instr_count), 3);
    check("prog_pc_end", 32'(pc_out), 2);
    check("prog_busy_end", 32'(busy), 0);

    // Conditional branches at [5] with both flag values
    br_op[0] = OP_JPNZ; br_z[0] = 1'b0; br_pc[0] = 11'd12;
    br_op[1] = OP_JPNZ; br_z[1] = 1'b1; br_pc[1] = 11'd6;
    br_op[2] = OP_JMPZ; br_z[2] = 1'b0; br_pc[2] = 11'd6;
    br_op[3] = OP_JMPZ; br_z[3] = 1'b1; br_pc[3] = 11'd12;
    for (int k = 0; k < 4; k++) begin
      clear_rom();
      rom[5]  = {br_op[k], 12'd12};
      rom[6]  = {OP_ENDOP, 12'h000};
      rom[12] = {OP_ENDOP, 12'h000};
      dpif.z_flag = br_z[k];
      start_pulse();
      run_to_halt(40, cyc, saw);
      check($sformatf("br%0d_halted", k), 32'(halted), 1);
      check($sformatf("br%0d_pc", k), 32'(pc_out), 32'(br_pc[k]));
      check($sformatf("br%0d_count", k), 32'(instr_count), 7);
      check($sformatf("br%0d_noissue", k), 32'(saw), 0);
    end
    dpif.z_flag = 1'b0;

    // add held by op_ready low for 4 cycles
    clear_rom();
    rom[0] = {OP_ADD, 12'h5A5};
    rom[1] = {OP_ENDOP, 12'h000};
    dpif.op_ready = 1'b0;
    start_pulse();
    wait_valid(10);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall%0d_valid", i), 32'(dpif.op_valid), 1);
      check($sformatf("stall%0d_opcode", i), 32'(dpif.opcode), 32'(OP_ADD));
      check($sformatf("stall%0d_operand", i), 32'(dpif.operand), 32'h5A5);
      check($sformatf("stall%0d_pc", i), 32'(pc_out), 0);
      tick();
    end
    check("stall_valid_pre", 32'(dpif.op_valid), 1);
    dpif.op_ready = 1'b1;
    tick();
    dpif.op_ready = 1'b0;
    check("retire_valid", 32'(dpif.op_valid), 0);
    check("retire_pc", 32'(pc_out), 1);
    check("retire_count", 32'(instr_count), 1);
    run_to_halt(20, cyc, saw);
    check("stall_halted", 32'(halted), 1);
    check("stall_count", 32'(instr_count), 2);

    // PC wrap: jpnz 12'hFFF lands on 2047, nop there wraps to 0
    clear_rom();
    rom[0]    = {OP_JPNZ, 12'hFFF};
    rom[1]    = {OP_ENDOP, 12'h000};
    rom[2047] = {OP_NOP, 12'h000};
    dpif.z_flag = 1'b0;
    start_pulse();
    tick();
    tick();
    check("wrap_pc_2047", 32'(pc_out), 2047);
    tick();
    tick();
    check("wrap_pc_0", 32'(pc_out), 0);
    dpif.z_flag = 1'b1;
    run_to_halt(20, cyc, saw);
    check("wrap_halted", 32'(halted), 1);
    check("wrap_pc_end", 32'(pc_out), 1);
    check("wrap_count", 32'(instr_count), 4);
    dpif.z_flag = 1'b0;

    // Undefined opcode 25 then endop
    clear_rom();
    rom[0] = {5'd25, 12'h000};
    rom[1] = {OP_ENDOP, 12'h000};
    dpif.op_ready = 1'b1;
    start_pulse();
    run_to_halt(20, cyc, saw);
    check("ill_halted", 32'(halted), 1);
    check("ill_flag", 32'(illegal), 1);
    check("ill_noissue", 32'(saw), 0);
    check("ill_count", 32'(instr_count), 2);
    check("ill_pc", 32'(pc_out), 1);
    start_pulse();
    check("restart_illegal", 32'(illegal), 0);
    check("restart_pc", 32'(pc_out), 0);
    check("restart_count", 32'(instr_count), 0);
    check("restart_halted", 32'(halted), 0);
    check("restart_busy", 32'(busy), 1);
    run_to_halt(20, cyc, saw);
    check("ill2_flag", 32'(illegal), 1);

    // rst while an op is being offered
    clear_rom();
    rom[0] = {OP_ADD, 12'h003};
    dpif.op_ready = 1'b0;
    start_pulse();
    wait_valid(10);
    check("pre_rst_valid", 32'(dpif.op_valid), 1);
    rst = 1'b1;
    start = 1'b1;
    dpif.op_ready = 1'b1;
    tick();
    check("rst_mid_valid", 32'(dpif.op_valid), 0);
    check("rst_mid_pc", 32'(pc_out), 0);
    check("rst_mid_count", 32'(instr_count), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_opcode", 32'(dpif.opcode), 0);
    tick();
    check("rst_hold_busy", 32'(busy), 0);
    rst = 1'b0;
    start = 1'b0;
    dpif.op_ready = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_halted", 32'(halted), 0);
    start_pulse();
    check("post_rst_start", 32'(busy), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
